hazard_controller: RTL and testbench

- Pipeline hazard controller for the 5-stage core. Sits beside the decode/execute/memory/writeback stages.
- Generates operand-forwarding selects for the execute-stage ALU inputs, and stall/flush controls for the fetch, decode and execute pipeline registers.
- Sequences multi-cycle load-use stalls with a small FSM.
- Keeps saturating stall and flush event counters for performance monitoring.

---
 rtl/hazard_if.sv | 45 ++++
 rtl/hazard_controller.sv | 134 +++++++++++++
 tb/tb_hazard_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller bundle: pipeline register/control signals going in,
// forwarding selects, stall/flush controls and event counters coming out.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  // Decode / execute source and destination registers
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RD_E;
  logic [4:0]       RD_M;
  logic [4:0]       RD_W;
  logic             RegWriteM;
  logic             RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic             cnt_clr;

  // Controls back to the pipeline
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  // Pipeline side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W,
           RegWriteM, RegWriteW, ResultSrcE, PCSrcE, cnt_clr,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           StallCount, FlushCount
  );

  // Hazard controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W,
           RegWriteM, RegWriteW, ResultSrcE, PCSrcE, cnt_clr,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage core: execute-stage operand
// forwarding, multi-cycle load-use stall sequencing, branch flushes and
// saturating stall/flush event counters.
module hazard_controller #(
  parameter int unsigned STALL_CYCLES = 1,   // bubbles per load-use hazard, 1..15
  parameter int unsigned CNT_W        = 16
) (
  input  logic     clk,
  input  logic     rst,                      // asynchronous, active low
  hazard_if.slave  hz
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  // Bubbles still owed after the one issued in IDLE
  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_rem;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t           w_next_state;
  logic [3:0]       w_next_rem;
  logic             w_lw_hit;
  logic             w_stall_f;
  logic             w_stall_d;
  logic             w_flush_d;
  logic             w_flush_e;

  // Forwarding selects: memory stage wins over writeback, x0 never forwarded
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.RD_M != 5'd0 && hz.RD_M == hz.Rs1E)
      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hz.RD_W != 5'd0 && hz.RD_W == hz.Rs1E)
      hz.ForwardAE = 2'b01;
    if (hz.RegWriteM && hz.RD_M != 5'd0 && hz.RD_M == hz.Rs2E)
      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hz.RD_W != 5'd0 && hz.RD_W == hz.Rs2E)
      hz.ForwardBE = 2'b01;
  end

  // Load in execute whose destination feeds the instruction in decode
  assign w_lw_hit = (hz.ResultSrcE == 2'b01) && (hz.RD_E != 5'd0) &&
                    ((hz.RD_E == hz.Rs1D) || (hz.RD_E == hz.Rs2D));

  // State register: stall FSM and remaining-bubble counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
    end
  end

  // Next-state logic: a taken branch cancels any stall in progress
  always_comb begin
    w_next_state = r_state;
    w_next_rem   = r_rem;
    if (hz.PCSrcE) begin
      w_next_state = S_IDLE;
      w_next_rem   = 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_lw_hit && STALL_CYCLES > 1) begin
            w_next_state = S_STALL;
            w_next_rem   = STALL_INIT;
          end
        end
        S_STALL: begin
          // A new hit while stalling is ignored; the bubble count is fixed
          w_next_rem = r_rem - 4'd1;
          if (r_rem == 4'd1)
            w_next_state = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_rem   = 4'd0;
        end
      endcase
    end
  end

  // Output logic: flush beats stall because the stalled consumer is discarded
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    if (hz.PCSrcE) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (r_state == S_STALL || w_lw_hit) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  assign hz.StallF = w_stall_f;
  assign hz.StallD = w_stall_d;
  assign hz.FlushD = w_flush_d;
  assign hz.FlushE = w_flush_e;

  // Saturating event counters; clear has priority over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (hz.cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_d && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (hz.PCSrcE && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.StallCount = r_stall_cnt;
  assign hz.FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller. Two instances: A (STALL_CYCLES=1, CNT_W=16)
// and B (STALL_CYCLES=3, CNT_W=4). Stimulus pushes the expected outputs of each
// cycle into a scoreboard queue; a monitor pops and compares at the falling edge.
module tb_hazard_controller;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rd_e, rd_m, rd_w;
    logic       rwm, rww;
    logic [1:0] rsrc;
    logic       pcsrc, clr;
  } stim_t;

  typedef struct {
    string      name;
    bit         dut_b;
    logic [1:0] fa, fb;
    logic [3:0] ctl;     // {StallF, StallD, FlushD, FlushE}
    int         sc, fc;
  } exp_t;

  localparam logic [3:0] NO = 4'b0000;
  localparam logic [3:0] ST = 4'b1101;
  localparam logic [3:0] FL = 4'b0011;

  logic  clk;
  logic  rst;
  stim_t sa;
  stim_t sbv;
  exp_t  sbq[$];
  exp_t  e;
  int    n_tests;
  int    n_fail;

  hazard_if #(.CNT_W(16)) ia ();
  hazard_if #(.CNT_W(4))  ib ();

  hazard_controller #(.STALL_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .hz(ia));
  hazard_controller #(.STALL_CYCLES(3), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hz(ib));

  assign ia.Rs1D = sa.rs1d;   assign ib.Rs1D = sbv.rs1d;
  assign ia.Rs2D = sa.rs2d;   assign ib.Rs2D = sbv.rs2d;
  assign ia.Rs1E = sa.rs1e;   assign ib.Rs1E = sbv.rs1e;
  assign ia.Rs2E = sa.rs2e;   assign ib.Rs2E = sbv.rs2e;
  assign ia.RD_E = sa.rd_e;   assign ib.RD_E = sbv.rd_e;
  assign ia.RD_M = sa.rd_m;   assign ib.RD_M = sbv.rd_m;
  assign ia.RD_W = sa.rd_w;   assign ib.RD_W = sbv.rd_w;
  assign ia.RegWriteM  = sa.rwm;   assign ib.RegWriteM  = sbv.rwm;
  assign ia.RegWriteW  = sa.rww;   assign ib.RegWriteW  = sbv.rww;
  assign ia.ResultSrcE = sa.rsrc;  assign ib.ResultSrcE = sbv.rsrc;
  assign ia.PCSrcE     = sa.pcsrc; assign ib.PCSrcE     = sbv.pcsrc;
  assign ia.cnt_clr    = sa.clr;   assign ib.cnt_clr    = sbv.clr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string name, input bit dut_b, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [3:0] ctl, input int sc, input int fc);
    exp_t x;
    x.name = name; x.dut_b = dut_b; x.fa = fa; x.fb = fb; x.ctl = ctl; x.sc = sc; x.fc = fc;
    sbq.push_back(x);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Monitor: packs {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount}
  initial begin
    n_tests = 0;
    n_fail  = 0;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        if (e.dut_b)
          check(e.name,
                {24'd0, ib.ForwardAE, ib.ForwardBE, ib.StallF, ib.StallD, ib.FlushD, ib.FlushE,
                 16'(ib.StallCount), 16'(ib.FlushCount)},
                {24'd0, e.fa, e.fb, e.ctl, 16'(e.sc), 16'(e.fc)});
        else
          check(e.name,
                {24'd0, ia.ForwardAE, ia.ForwardBE, ia.StallF, ia.StallD, ia.FlushD, ia.FlushE,
                 ia.StallCount, ia.FlushCount},
                {24'd0, e.fa, e.fb, e.ctl, 16'(e.sc), 16'(e.fc)});
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b0;
    sa  = '0;
    sbv = '0;

    // Reset state
    step(); expect_o("reset_a", 0, 2'b00, 2'b00, NO, 0, 0);
    step(); expect_o("reset_b", 1, 2'b00, 2'b00, NO, 0, 0);
    step(); rst = 1'b1; expect_o("idle_a", 0, 2'b00, 2'b00, NO, 0, 0);

    // Forwarding on A
    step(); sa.rwm = 1; sa.rd_m = 5; sa.rww = 1; sa.rd_w = 5; sa.rs1e = 5; sa.rs2e = 5;
    expect_o("fwd_mem_prio", 0, 2'b10, 2'b10, NO, 0, 0);
    step(); sa.rwm = 0;
    expect_o("fwd_wb", 0, 2'b01, 2'b01, NO, 0, 0);
    step(); sa.rd_w = 0;
    expect_o("fwd_none", 0, 2'b00, 2'b00, NO, 0, 0);
    step(); sa.rwm = 1; sa.rd_m = 5; sa.rww = 1; sa.rd_w = 6; sa.rs2e = 6;
    expect_o("fwd_split", 0, 2'b10, 2'b01, NO, 0, 0);
    step(); sa.rd_m = 0; sa.rd_w = 0; sa.rs1e = 0; sa.rs2e = 0;
    expect_o("fwd_x0", 0, 2'b00, 2'b00, NO, 0, 0);

    // Single-cycle load-use on A
    step(); sa = '0; sa.rsrc = 2'b01; sa.rd_e = 7; sa.rs2d = 7;
    expect_o("lu1_stall", 0, 2'b00, 2'b00, ST, 0, 0);
    step(); sa.rsrc = 2'b00;
    expect_o("lu1_done", 0, 2'b00, 2'b00, NO, 1, 0);
    step(); sa.rsrc = 2'b01; sa.rd_e = 0; sa.rs1d = 0; sa.rs2d = 0;
    expect_o("lu_x0", 0, 2'b00, 2'b00, NO, 1, 0);
    step(); sa.rd_e = 9; sa.rs1d = 9;
    expect_o("lu1_rs1", 0, 2'b00, 2'b00, ST, 1, 0);
    step(); sa = '0;
    expect_o("lu1_rs1_done", 0, 2'b00, 2'b00, NO, 2, 0);

    // Three-cycle load-use on B
    step(); sbv.rsrc = 2'b01; sbv.rd_e = 7; sbv.rs2d = 7;
    expect_o("lu3_c1", 1, 2'b00, 2'b00, ST, 0, 0);
    step(); sbv.rsrc = 2'b00;
    expect_o("lu3_c2", 1, 2'b00, 2'b00, ST, 1, 0);
    step(); expect_o("lu3_c3", 1, 2'b00, 2'b00, ST, 2, 0);
    step(); expect_o("lu3_end", 1, 2'b00, 2'b00, NO, 3, 0);

    // Branch during stall on B
    step(); sbv.clr = 1;
    expect_o("clr_b", 1, 2'b00, 2'b00, NO, 3, 0);
    step(); sbv.clr = 0; sbv.rsrc = 2'b01;
    expect_o("br_c1", 1, 2'b00, 2'b00, ST, 0, 0);
    step(); sbv.rsrc = 2'b00; sbv.pcsrc = 1;
    expect_o("br_flush", 1, 2'b00, 2'b00, FL, 1, 0);
    step(); sbv.pcsrc = 0;
    expect_o("br_after", 1, 2'b00, 2'b00, NO, 1, 1);
    step(); sbv.rsrc = 2'b01; sbv.pcsrc = 1;
    expect_o("br_vs_hit", 1, 2'b00, 2'b00, FL, 1, 1);
    step(); sbv.rsrc = 2'b00; sbv.pcsrc = 0;
    expect_o("br_vs_hit_after", 1, 2'b00, 2'b00, NO, 1, 2);

    // Flush counter saturation and clear on B (4-bit)
    for (int i = 0; i < 20; i++) begin
      step(); sbv.pcsrc = 1;
      expect_o($sformatf("fsat_%0d", i), 1, 2'b00, 2'b00, FL, 1, imin(2 + i, 15));
    end
    step(); sbv.clr = 1;
    expect_o("fclr", 1, 2'b00, 2'b00, FL, 1, 15);
    step(); sbv.clr = 0; sbv.pcsrc = 0;
    expect_o("fclr_after", 1, 2'b00, 2'b00, NO, 0, 0);

    // Stall counter saturation with a held hit; hit ignored while stalling
    for (int i = 0; i < 20; i++) begin
      step(); sbv.rsrc = 2'b01;
      expect_o($sformatf("ssat_%0d", i), 1, 2'b00, 2'b00, ST, imin(i, 15), 0);
    end
    step(); sbv.rsrc = 2'b00;
    expect_o("ssat_tail", 1, 2'b00, 2'b00, ST, 15, 0);
    step(); expect_o("ssat_idle", 1, 2'b00, 2'b00, NO, 15, 0);
    step(); sbv.clr = 1;
    expect_o("sclr", 1, 2'b00, 2'b00, NO, 15, 0);
    step(); sbv.clr = 0;
    expect_o("sclr_after", 1, 2'b00, 2'b00, NO, 0, 0);

    // Asynchronous reset in the middle of a stall on B
    step(); sbv.rsrc = 2'b01;
    expect_o("rst_c1", 1, 2'b00, 2'b00, ST, 0, 0);
    step(); sbv.rsrc = 2'b00;
    expect_o("rst_c2", 1, 2'b00, 2'b00, ST, 1, 0);
    step(); rst = 1'b0;
    expect_o("rst_async", 1, 2'b00, 2'b00, NO, 0, 0);
    step(); expect_o("rst_held", 1, 2'b00, 2'b00, NO, 0, 0);
    step(); rst = 1'b1;
    expect_o("rst_release", 1, 2'b00, 2'b00, NO, 0, 0);
    step(); expect_o("rst_after", 1, 2'b00, 2'b00, NO, 0, 0);

    // Every pushed expectation must have been consumed by the monitor
    step();
    step();
    check("sb_drain", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
